// File: rtl/lsu_bus_if.sv
// Memory-stage bus master: one load/store per instruction over a req/gnt/rvalid bus with a WAIT timeout.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_bus_if #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | waiting for a MEM-stage access
    // REQ   | bus_req high, holding address/data until grant
    // WAIT  | granted, counting cycles until rvalid or timeout
    // RESP  | one-cycle rsp_valid with result/fault
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        misalign;
    logic [31:0] load_data;
    logic        timeout;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = req_addr[0];
            default:        misalign = |req_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Lane extraction uses the captured address offset and width code.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{b[7]}}, b};
            3'b100:  load_data = {24'h0, b};
            3'b001:  load_data = {{16{h[15]}}, h};
            3'b101:  load_data = {16'h0, h};
            default: load_data = bus_rdata;
        endcase
        if (we_q) load_data = 32'h0;
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = misalign ? RESP : REQ;
            REQ:  if (bus_gnt) state_d = bus_rvalid ? RESP : WAIT;
            WAIT: if (bus_rvalid || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= 16'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        be_q     <= req_we ? req_sel : 4'hF;
                        wdata_q  <= req_wdata;
                        cnt_q    <= 16'h0;
                        rdata_q  <= 32'h0;
                        fault_q  <= misalign;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        cnt_q <= 16'h0;
                        if (bus_rvalid) rdata_q <= load_data;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 16'h1;
                    // rvalid on the last timeout cycle still completes normally
                    if (bus_rvalid)   rdata_q <= load_data;
                    else if (timeout) fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        bus_req   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_fault = 1'b0;
        case (state_q)
            IDLE: stall = req_valid;
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
            end
            WAIT: stall = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_fault = fault_q;
            end
            default: ;
        endcase
    end

    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if with TIMEOUT_CYC=4; expectations are hand-computed per vector.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [3:0]  req_sel = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, rsp_valid, rsp_fault, bus_req, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_bus_if #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_sel(req_sel), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the accept cycle; gnt arrives gw cycles into REQ, rvalid rw cycles
    // after gnt (rw<0: never). Latency is the cycle index at which rsp_valid is seen.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [3:0] sel, input logic [31:0] wd,
                             input int gw, input int rw, input logic [31:0] rd,
                             input logic exp_bus, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_rd,
                             input logic exp_fault, input int exp_lat);
        int  n;
        bit  done;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3;
        req_sel = sel; req_wdata = wd;
        @(negedge clk);
        chk({tag, "_stall_acc"}, stall, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_sel = 4'h0;
        n = 1; done = 1'b0;
        while (!done && n < 40) begin
            bus_gnt    = exp_bus && (n == 1 + gw);
            bus_rvalid = exp_bus && (rw >= 0) && (n == 1 + gw + rw);
            bus_rdata  = bus_rvalid ? rd : 32'hDEAD_BEEF;
            @(negedge clk);
            if (rsp_valid) done = 1'b1;
            else begin
                chk({tag, "_stall"}, stall, 1'b1);
                if (exp_bus && n <= 1 + gw) begin
                    chk({tag, "_bus_req"}, bus_req, 1'b1);
                    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
                    chk({tag, "_bus_be"}, bus_be, exp_be);
                    chk({tag, "_bus_we"}, bus_we, we);
                    chk({tag, "_bus_wdata"}, bus_wdata, wd);
                end else begin
                    chk({tag, "_bus_req_low"}, bus_req, 1'b0);
                end
                @(posedge clk); #1;
                n++;
            end
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_fault"}, rsp_fault, exp_fault);
        chk({tag, "_stall_resp"}, stall, 1'b0);
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #12;
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fault", rsp_fault, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // tag        we   addr          f3      sel   wdata          gw rw rdata          bus  baddr          be    exp_rd         flt lat
        do_access("lb",   1'b0, 32'h0000_0103, 3'b000, 4'h0, 32'h0,          0, 2, 32'h80FF_1234, 1'b1, 32'h0000_0100, 4'hF, 32'hFFFF_FF80, 1'b0, 4);
        do_access("lhu",  1'b0, 32'h0000_0102, 3'b101, 4'h0, 32'h0,          0, 1, 32'hBEEF_0000, 1'b1, 32'h0000_0100, 4'hF, 32'h0000_BEEF, 1'b0, 3);
        do_access("lw",   1'b0, 32'h0000_0100, 3'b010, 4'h0, 32'h0,          0, 0, 32'hCAFE_F00D, 1'b1, 32'h0000_0100, 4'hF, 32'hCAFE_F00D, 1'b0, 2);
        do_access("lh",   1'b0, 32'h0000_0100, 3'b001, 4'h0, 32'h0,          0, 0, 32'h1234_8001, 1'b1, 32'h0000_0100, 4'hF, 32'hFFFF_8001, 1'b0, 2);
        do_access("lbu",  1'b0, 32'h0000_0101, 3'b100, 4'h0, 32'h0,          0, 0, 32'h0000_9A00, 1'b1, 32'h0000_0100, 4'hF, 32'h0000_009A, 1'b0, 2);
        do_access("rsvd", 1'b0, 32'h0000_0300, 3'b011, 4'h0, 32'h0,          0, 0, 32'h8765_4321, 1'b1, 32'h0000_0300, 4'hF, 32'h8765_4321, 1'b0, 2);
        do_access("sb",   1'b1, 32'h0000_0201, 3'b000, 4'h2, 32'h0000_AB00,  0, 1, 32'h1111_1111, 1'b1, 32'h0000_0200, 4'h2, 32'h0,         1'b0, 3);
        do_access("gntw", 1'b0, 32'h0000_0404, 3'b010, 4'h0, 32'h0,          5, 0, 32'h0BAD_F00D, 1'b1, 32'h0000_0404, 4'hF, 32'h0BAD_F00D, 1'b0, 7);
        do_access("tmo",  1'b0, 32'h0000_0500, 3'b010, 4'h0, 32'h0,          0, -1, 32'h0,        1'b1, 32'h0000_0500, 4'hF, 32'h0,         1'b1, 6);
        do_access("tlast",1'b0, 32'h0000_0500, 3'b010, 4'h0, 32'h0,          0, 4, 32'h2468_ACE0, 1'b1, 32'h0000_0500, 4'hF, 32'h2468_ACE0, 1'b0, 6);
`ifdef LSU_MISALIGN_TRAP_EN
        do_access("mis",  1'b0, 32'h0000_0102, 3'b010, 4'h0, 32'h0,          0, 0, 32'h1122_3344, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 1);
`else
        do_access("mis",  1'b0, 32'h0000_0102, 3'b010, 4'h0, 32'h0,          0, 0, 32'h1122_3344, 1'b1, 32'h0000_0100, 4'hF, 32'h1122_3344, 1'b0, 2);
`endif

        // Reset in WAIT, then a late rvalid while idle.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0600; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("rstw_in_wait", stall, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_stall", stall, 1'b0);
        chk("rstw_bus_req", bus_req, 1'b0);
        chk("rstw_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hFEED_FACE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_valid", rsp_valid, 1'b0);
            chk("late_stall", stall, 1'b0);
            chk("late_bus_req", bus_req, 1'b0);
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
        end
        do_access("lw_after", 1'b0, 32'h0000_0700, 3'b010, 4'h0, 32'h0,     0, 1, 32'h1357_9BDF, 1'b1, 32'h0000_0700, 4'hF, 32'h1357_9BDF, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
